// File: rtl/isa_pkg.sv
// Shared definitions for the ISA dispatcher: instruction classes, field
// positions inside the 64-bit instruction word and the FSM state encoding.
package isa_pkg;

  localparam logic [3:0] CLS_NOP  = 4'h0;
  localparam logic [3:0] CLS_EXEC = 4'h1;
  localparam logic [3:0] CLS_BAR  = 4'hE;
  localparam logic [3:0] CLS_HALT = 4'hF;

  localparam int CLS_MSB = 63;
  localparam int CLS_LSB = 60;
  localparam int IDX_MSB = 59;
  localparam int IDX_LSB = 58;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_DECODE    = 3'd2,
    S_ISSUE     = 3'd3,
    S_BARRIER   = 3'd4,
    S_HALT      = 3'd5
  } state_t;

endpackage

// File: rtl/isa_dispatch_if.sv
// FIFO read port plus the shared issue bus towards the execution units.
// master = dispatcher side, slave = FIFO/unit side.
interface isa_dispatch_if #(
  parameter int DATA_W    = 64,
  parameter int NUM_UNITS = 4
);
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [DATA_W-1:0]    fifo_dout;
  logic [NUM_UNITS-1:0] unit_valid;
  logic [NUM_UNITS-1:0] unit_ready;
  logic [NUM_UNITS-1:0] unit_busy;
  logic [DATA_W-1:0]    unit_instr;

  modport master (
    input  fifo_empty, fifo_dout, unit_ready, unit_busy,
    output fifo_rd_en, unit_valid, unit_instr
  );

  modport slave (
    output fifo_empty, fifo_dout, unit_ready, unit_busy,
    input  fifo_rd_en, unit_valid, unit_instr
  );
endinterface

// File: rtl/isa_dispatch.sv
// Pops instructions from the ISA FIFO, decodes the class field and issues
// EXEC words to one execution unit over valid/ready. Handles NOP, BARRIER
// (wait for all units idle) and HALT/resume.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | idle; pops one word when enabled and FIFO not empty
// WAIT_DATA | FIFO read data arrives this cycle; capture it
// DECODE    | classify captured word, flag bad index / unknown class
// ISSUE     | hold unit_valid[idx] and unit_instr until the unit accepts
// BARRIER   | wait until every unit reports not busy
// HALT      | no fetching until a resume pulse
module isa_dispatch
  import isa_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int NUM_UNITS = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             resume,
  isa_dispatch_if.master   bus,
  output logic             halted,
  output logic [CNT_W-1:0] issue_count,
  output logic [1:0]       err
);

  localparam logic [2:0] NUM_UNITS_W = 3'(NUM_UNITS);

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    instr_q, instr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           err_q, err_d;
  logic                 rd_en;
  logic [NUM_UNITS-1:0] valid_vec;
  logic [3:0]           cls;
  logic [1:0]           idx;

  assign cls = instr_q[CLS_MSB:CLS_LSB];
  assign idx = instr_q[IDX_MSB:IDX_LSB];

  // State and datapath registers; reset discards any in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      instr_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state, decode and issue outputs.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_en     = 1'b0;
    valid_vec = '0;
    case (state_q)
      S_FETCH: begin
        if (enable && !bus.fifo_empty) begin
          rd_en   = 1'b1;
          state_d = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        instr_d = bus.fifo_dout;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          CLS_NOP:  state_d = S_FETCH;
          CLS_EXEC: begin
            if ({1'b0, idx} < NUM_UNITS_W) begin
              state_d = S_ISSUE;
            end else begin
              err_d[0] = 1'b1;
              state_d  = S_FETCH;
            end
          end
          CLS_BAR:  state_d = S_BARRIER;
          CLS_HALT: state_d = S_HALT;
          default: begin
            err_d[1] = 1'b1;
            state_d  = S_FETCH;
          end
        endcase
      end
      S_ISSUE: begin
        for (int i = 0; i < NUM_UNITS; i++) begin
          valid_vec[i] = (idx == 2'(i));
        end
        if (|(valid_vec & bus.unit_ready)) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_FETCH;
        end
      end
      S_BARRIER: begin
        if (bus.unit_busy == '0) begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (resume) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // The read strobe is gated by reset so nothing is popped while held in reset.
  assign bus.fifo_rd_en = rd_en & ~rst;
  assign bus.unit_valid = valid_vec;
  assign bus.unit_instr = instr_q;
  assign halted         = (state_q == S_HALT);
  assign issue_count    = cnt_q;
  assign err            = err_q;

endmodule

// File: tb/tb_isa_dispatch.sv
// Directed bench for isa_dispatch with a small FIFO model and unit
// ready/busy driven directly from the stimulus.
module tb_isa_dispatch;
  import isa_pkg::*;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        resume;
  logic        halted;
  logic [31:0] issue_count;
  logic [1:0]  err;

  int n_checks;
  int n_err;

  isa_dispatch_if #(.DATA_W(64), .NUM_UNITS(4)) bus ();

  isa_dispatch #(.DATA_W(64), .NUM_UNITS(4), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .resume      (resume),
    .bus         (bus),
    .halted      (halted),
    .issue_count (issue_count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mem [32];
  int          wr_ptr;
  int          rd_ptr;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_dout <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_checks       = 0;
    n_err          = 0;
    wr_ptr         = 0;
    rd_ptr         = 0;
    bus.fifo_dout  = '0;
    bus.unit_ready = 4'b0000;
    bus.unit_busy  = 4'b0000;
    rst            = 1'b1;
    enable         = 1'b0;
    resume         = 1'b0;
    nxt();
    nxt();
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("rst_valid", 64'(bus.unit_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(issue_count), 64'd0);
    check("rst_instr", bus.unit_instr, 64'd0);

    // Empty FIFO, enabled: never reads.
    rst    = 1'b0;
    enable = 1'b1;
    resume = 1'b1;
    #1;
    resume = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nxt();
      check("empty_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    end
    check("empty_valid", 64'(bus.unit_valid), 64'd0);
    check("empty_halted", 64'(halted), 64'd0);
    check("empty_count", 64'(issue_count), 64'd0);
    check("empty_err", 64'(err), 64'd0);

    // EXEC to unit 1 with ready high: valid 3 cycles after rd_en.
    bus.unit_ready = 4'b0010;
    push(64'h1400_0000_0000_00AA);
    #1;
    check("e1_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    nxt();
    check("e1_rd_en_1cyc", 64'(bus.fifo_rd_en), 64'd0);
    check("e1_valid_c1", 64'(bus.unit_valid), 64'd0);
    nxt();
    check("e1_valid_c2", 64'(bus.unit_valid), 64'd0);
    nxt();
    check("e1_valid_c3", 64'(bus.unit_valid), 64'h2);
    check("e1_instr", bus.unit_instr, 64'h1400_0000_0000_00AA);
    check("e1_count_pre", 64'(issue_count), 64'd0);
    nxt();
    check("e1_count", 64'(issue_count), 64'd1);
    check("e1_valid_drop", 64'(bus.unit_valid), 64'd0);

    // EXEC to unit 2 with ready low for 5 cycles.
    bus.unit_ready = 4'b0000;
    push(64'h1800_0000_0000_0BBB);
    #1;
    check("e2_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    nxt();
    nxt();
    nxt();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) enable = 1'b0;
      #1;
      check("e2_hold_valid", 64'(bus.unit_valid), 64'h4);
      check("e2_hold_instr", bus.unit_instr, 64'h1800_0000_0000_0BBB);
      check("e2_hold_count", 64'(issue_count), 64'd1);
      nxt();
    end
    enable         = 1'b1;
    bus.unit_ready = 4'b0100;
    #1;
    check("e2_hs_valid", 64'(bus.unit_valid), 64'h4);
    check("e2_hs_count_pre", 64'(issue_count), 64'd1);
    nxt();
    check("e2_count", 64'(issue_count), 64'd2);
    check("e2_valid_drop", 64'(bus.unit_valid), 64'd0);

    // BARRIER with unit 2 busy, then EXEC to unit 3.
    bus.unit_ready = 4'b1111;
    bus.unit_busy  = 4'b0100;
    push(64'hE000_0000_0000_0000);
    push(64'h1C00_0000_0000_0CCC);
    #1;
    check("bar_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    nxt();
    nxt();
    nxt();
    for (int i = 0; i < 6; i++) begin
      check("bar_wait_rd_en", 64'(bus.fifo_rd_en), 64'd0);
      check("bar_wait_valid", 64'(bus.unit_valid), 64'd0);
      nxt();
    end
    bus.unit_busy = 4'b0000;
    #1;
    check("bar_last_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    nxt();
    check("bar_exec_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    nxt();
    nxt();
    nxt();
    check("bar_exec_valid", 64'(bus.unit_valid), 64'h8);
    check("bar_exec_instr", bus.unit_instr, 64'h1C00_0000_0000_0CCC);
    nxt();
    check("bar_exec_count", 64'(issue_count), 64'd3);

    // HALT then EXEC to unit 0; resume releases it.
    push(64'hF000_0000_0000_0000);
    push(64'h1000_0000_0000_0DDD);
    #1;
    check("halt_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    nxt();
    nxt();
    check("halt_pre", 64'(halted), 64'd0);
    nxt();
    for (int i = 0; i < 4; i++) begin
      check("halt_halted", 64'(halted), 64'd1);
      check("halt_no_rd", 64'(bus.fifo_rd_en), 64'd0);
      nxt();
    end
    resume = 1'b1;
    #1;
    check("halt_resume_cyc", 64'(halted), 64'd1);
    nxt();
    resume = 1'b0;
    #1;
    check("halt_released", 64'(halted), 64'd0);
    check("halt_exec_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    nxt();
    nxt();
    nxt();
    check("halt_exec_valid", 64'(bus.unit_valid), 64'h1);
    check("halt_exec_instr", bus.unit_instr, 64'h1000_0000_0000_0DDD);
    nxt();
    check("halt_exec_count", 64'(issue_count), 64'd4);

    // Unknown class 0x7 sets err[1]; a NOP afterwards changes nothing.
    push(64'h7000_0000_0000_0001);
    #1;
    check("bad_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    nxt();
    nxt();
    check("bad_err_pre", 64'(err), 64'd0);
    nxt();
    check("bad_err", 64'(err), 64'h2);
    check("bad_valid", 64'(bus.unit_valid), 64'd0);
    push(64'h0000_0000_0000_0055);
    nxt();
    nxt();
    nxt();
    check("nop_state_fetch_valid", 64'(bus.unit_valid), 64'd0);
    check("nop_err", 64'(err), 64'h2);
    check("nop_count", 64'(issue_count), 64'd4);

    // Reset during ISSUE.
    bus.unit_ready = 4'b0000;
    push(64'h1400_0000_0000_0EEE);
    push(64'h1800_0000_0000_0FFF);
    #1;
    check("rsti_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    nxt();
    nxt();
    nxt();
    check("rsti_valid", 64'(bus.unit_valid), 64'h2);
    rst = 1'b1;
    #1;
    check("rsti_async_valid", 64'(bus.unit_valid), 64'd0);
    check("rsti_count", 64'(issue_count), 64'd0);
    check("rsti_err", 64'(err), 64'd0);
    check("rsti_instr", bus.unit_instr, 64'd0);
    check("rsti_rd_en_held", 64'(bus.fifo_rd_en), 64'd0);
    nxt();
    rst            = 1'b0;
    bus.unit_ready = 4'b0100;
    #1;
    check("rsti_rel_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    nxt();
    nxt();
    nxt();
    check("rsti_next_valid", 64'(bus.unit_valid), 64'h4);
    check("rsti_next_instr", bus.unit_instr, 64'h1800_0000_0000_0FFF);
    nxt();
    check("rsti_next_count", 64'(issue_count), 64'd1);
    check("rsti_fifo_drained", 64'(bus.fifo_empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
